mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter and sequencer for a single-ported, fixed-latency unified memory. It sits between the CPU's instruction-fetch path and data-access path and the shared memory. Each access is latched, the memory is driven for LATENCY cycles, and the result is returned with a one-cycle valid pulse. One access is outstanding at a time.

## Interface
- LATENCY, 4: memory access cycles (mem_en held high this long); legal range 1–15.
- ADDR_W, 16: address width.
- DATA_W, 16: data width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  instruction-fetch read request.
- i_addr  in  ADDR_W  fetch address.
- i_ready  out  1  grant/accept pulse to fetch.
- i_valid  out  1  one-cycle fetch-data-valid pulse.
- i_rdata  out  DATA_W  fetch data, valid with i_valid.
- d_req  in  1  data-access request.
- d_wr  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_ready  out  1  grant/accept pulse to data.
- d_valid  out  1  one-cycle completion pulse (reads and writes).
- d_rdata  out  DATA_W  read data; 0 for writes.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid on the last mem_en cycle.

## Operation
- FSM has three states: IDLE, BUSY, DONE.
- IDLE: if any request is pending, grant exactly one requester.
  - The matching *_ready is combinational, high in this cycle only.
  - The arbiter latches owner, addr, wr, and wdata, loads the counter with LATENCY-1, and goes to BUSY.
  - With no request pending, it stays in IDLE.
- BUSY:
  - mem_en=1. mem_addr, mem_wr, and mem_wdata come from the latches and are stable for all LATENCY cycles.
  - The counter decrements each cycle.
  - At count 0, the arbiter captures mem_rdata (or 0 for writes) into the result register and goes to DONE.
- DONE: owner's *_valid=1 and *_rdata=result for one cycle, then go to IDLE. No grant is issued in DONE.
- Arbitration (default): when both request in the same IDLE cycle, d wins (fixed data priority).
- Requester rules:
  - Hold *_req until *_ready is seen.
  - Dropping req before the grant is legal and no access occurs.
  - Inputs may change freely after *_ready, because the arbiter uses its latched copies.
  - A requester may assert req during BUSY or DONE. It is considered at the next IDLE.
- Only the owner's *_valid pulses. The non-owner's valid and rdata stay 0.
- *_rdata is 0 whenever *_valid is 0.
- d_wr is ignored unless d is granted. mem_wr is never 1 for an i access.

## Timing
- Grant at cycle T; mem_en high T+1..T+LATENCY; *_valid at T+LATENCY+1; next possible grant T+LATENCY+2.
- Throughput is one access per LATENCY+2 cycles.
- Reset values: state=IDLE, and every output is 0 (ready, valid, rdata, mem_en, mem_wr, mem_addr, mem_wdata). The RR pointer favours d.
- rst during BUSY or DONE: the next cycle is IDLE with all outputs 0.
  - The in-flight access is dropped and no valid is issued.
  - The requester must re-issue.
- rst has priority over every grant. No *_ready is asserted in a cycle where rst=1.
- The counter never wraps: it is loaded only at grant and stops at 0.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on simultaneous requests.
  - A 1-bit last-winner register is updated at each grant.
  - On a tie, the requester that did not win the last grant wins.
  - Uncontested grants still update the pointer.
- MEM_ARB_RR_EN undefined: strict d priority and no pointer register.

## Structure
- Package mem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, BUSY, DONE};
  - typedef enum req_id_t {REQ_I, REQ_D};
  - constant LAT_CNT_W = 4.
- Sub-module mem_arb_cnt: loadable LAT_CNT_W-bit down-counter with load, dec, and is_zero; synchronous rst to 0.
- Top level holds the FSM, grant logic, latches, and result register.

## Test plan
- d read only, d_addr=0x0010, mem_rdata=0xBEEF, LATENCY=4 -> d_ready at T0; mem_en and mem_addr=0x0010 with mem_wr=0 during T1–T4; d_valid with d_rdata=0xBEEF at T5 only.
- d write, d_addr=0x0020, d_wdata=0x1234 -> mem_wr=1 and mem_wdata=0x1234 during T1–T4; d_valid at T5 with d_rdata=0x0000; i_valid stays 0.
- i_req and d_req together, default build -> d granted at T0, i_ready at T6, i_valid at T11. With MEM_ARB_RR_EN, repeating the tie after that sequence -> d wins (i won last).
- i_addr changed from 0x0040 to 0x0099 the cycle after i_ready -> mem_addr stays 0x0040 for all of T1–T4.
- rst asserted at T2 of a d read -> at T3 state is IDLE and all outputs are 0; no d_valid ever for that access.
- Back-to-back i reads with i_req held high -> grants at T0 and T6; i_valid at T5 and T11 with the matching mem_rdata.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the mem_arbiter block:
//                FSM state encoding, requester identifiers and the width of
//                the latency down-counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    // Width of the latency counter; wide enough for LATENCY-1 up to 14.
    localparam int LAT_CNT_W = 4;

    // Sequencer states: waiting for a request, driving memory, returning data.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Identity of the requester that owns the current access.
    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_cnt.sv
// ============================================================================
//  Module      : mem_arb_cnt
//  Description : Loadable down-counter used to time the memory access.
//                Loads on i_load, decrements on i_dec and saturates at zero,
//                so it can never wrap back to a large value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_cnt
    import mem_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [LAT_CNT_W-1:0] i_load_val,
    input  logic                 i_dec,
    output logic                 o_is_zero
);

    logic [LAT_CNT_W-1:0] r_count;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_is_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester (instruction fetch / data access) arbiter and
//                sequencer for a single-ported fixed-latency memory. One
//                access is outstanding at a time: grant in IDLE, drive the
//                memory for LATENCY cycles in BUSY, return a one-cycle valid
//                pulse in DONE.
//                Build option MEM_ARB_RR_EN: round-robin between the two
//                requesters on simultaneous requests (default: data side
//                always wins a tie).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    // Instruction-fetch port (read only)
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    // Data-access port (read / write)
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    // Memory side
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [LAT_CNT_W-1:0] C_CNT_LOAD = LAT_CNT_W'(LATENCY - 1);

    arb_state_t        r_state;
    req_id_t           r_owner;
    logic              r_mem_en;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_result;
    logic              r_i_valid;
    logic              r_d_valid;

    logic              w_pick_d;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_grant;
    logic              w_cnt_zero;

`ifdef MEM_ARB_RR_EN
    // Winner of the most recent grant; reset to REQ_I so that d wins the
    // first tie.
    req_id_t           r_last;
`endif

    // Pick a winner among the requesters and qualify it with IDLE and !rst,
    // so no ready can be raised while reset is asserted.
    always_comb begin
        w_pick_d = d_req;
`ifdef MEM_ARB_RR_EN
        if (i_req && d_req) begin
            w_pick_d = (r_last == REQ_I);
        end
`endif
        w_grant_d = (r_state == IDLE) && !rst && d_req && w_pick_d;
        w_grant_i = (r_state == IDLE) && !rst && i_req && !w_pick_d;
        w_grant   = w_grant_d || w_grant_i;
    end

    assign i_ready = w_grant_i;
    assign d_ready = w_grant_d;

    // Access timer: loaded with LATENCY-1 at grant, counts down in BUSY.
    mem_arb_cnt u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_grant),
        .i_load_val (C_CNT_LOAD),
        .i_dec      (r_state == BUSY),
        .o_is_zero  (w_cnt_zero)
    );

    // Main sequencer: latches the granted request, drives the memory while
    // BUSY, captures the read result and raises the owner's valid for one
    // cycle in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= REQ_I;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_result    <= '0;
            r_i_valid   <= 1'b0;
            r_d_valid   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_i_valid <= 1'b0;
                    r_d_valid <= 1'b0;
                    if (w_grant) begin
                        r_state     <= BUSY;
                        r_owner     <= w_grant_d ? REQ_D : REQ_I;
                        r_mem_en    <= 1'b1;
                        // A fetch is always a read, whatever d_wr says.
                        r_mem_wr    <= w_grant_d && d_wr;
                        r_mem_addr  <= w_grant_d ? d_addr : i_addr;
                        r_mem_wdata <= w_grant_d ? d_wdata : '0;
                    end
                end
                BUSY: begin
                    if (w_cnt_zero) begin
                        r_state     <= DONE;
                        r_mem_en    <= 1'b0;
                        r_mem_wr    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        // Writes return zero data on completion.
                        r_result    <= r_mem_wr ? '0 : mem_rdata;
                        r_i_valid   <= (r_owner == REQ_I);
                        r_d_valid   <= (r_owner == REQ_D);
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_i_valid <= 1'b0;
                    r_d_valid <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_en  <= 1'b0;
                    r_mem_wr  <= 1'b0;
                    r_i_valid <= 1'b0;
                    r_d_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember the winner of every grant, contested or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= REQ_I;
        end else if (w_grant) begin
            r_last <= w_grant_d ? REQ_D : REQ_I;
        end
    end
`endif

    assign mem_en    = r_mem_en;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_valid   = r_i_valid;
    assign d_valid   = r_d_valid;
    // Read data is forced to zero outside the owner's valid pulse.
    assign i_rdata   = r_i_valid ? r_result : '0;
    assign d_rdata   = r_d_valid ? r_result : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A cycle-count based
//                reference model is compared against the DUT every cycle;
//                directed sequences add hand-computed literal checks, then
//                randomized traffic follows.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int LAT = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ready;
    logic          i_valid;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_wr = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready;
    logic          d_valid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter #(.LATENCY(LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_valid   (i_valid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: an access granted in cycle t owns the memory for
    // cycles t+1..t+LAT, returns data in t+LAT+1 and frees the arbiter
    // for a new grant at t+LAT+2.
    // ------------------------------------------------------------------
    int            mc = 0;
    bit            m_busy = 1'b0;
    int            m_t = 0;
    bit            m_own_d = 1'b0;
    bit            m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_res = '0;
    bit            m_last_d = 1'b0;
    int            ph;
    bit            e_gi, e_gd, e_en, e_iv, e_dv;

    always @(negedge clk) begin
        ph   = mc - m_t;
        e_gi = 1'b0;
        e_gd = 1'b0;
        if (!m_busy && !rst && (i_req || d_req)) begin
            if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                e_gd = !m_last_d;
`else
                e_gd = 1'b1;
`endif
            end else begin
                e_gd = d_req;
            end
            e_gi = !e_gd;
        end
        e_en = m_busy && (ph >= 1) && (ph <= LAT);
        e_dv = m_busy && (ph == LAT + 1) && m_own_d;
        e_iv = m_busy && (ph == LAT + 1) && !m_own_d;

        chk("model i_ready", 32'(i_ready), 32'(e_gi));
        chk("model d_ready", 32'(d_ready), 32'(e_gd));
        chk("model mem_en",  32'(mem_en),  32'(e_en));
        chk("model i_valid", 32'(i_valid), 32'(e_iv));
        chk("model d_valid", 32'(d_valid), 32'(e_dv));
        chk("model i_rdata", 32'(i_rdata), e_iv ? 32'(m_res) : 32'd0);
        chk("model d_rdata", 32'(d_rdata), e_dv ? 32'(m_res) : 32'd0);
        if (e_en) begin
            chk("model mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("model mem_wr",   32'(mem_wr),   32'(m_wr));
            if (m_wr) chk("model mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        end else begin
            chk("model mem_wr idle", 32'(mem_wr), 32'd0);
        end

        if (rst) begin
            m_busy   = 1'b0;
            m_last_d = 1'b0;
        end else if (m_busy) begin
            if (ph == LAT)     m_res  = m_wr ? '0 : mem_rdata;
            if (ph == LAT + 1) m_busy = 1'b0;
        end else if (e_gi || e_gd) begin
            m_busy   = 1'b1;
            m_t      = mc;
            m_own_d  = e_gd;
            m_wr     = e_gd && d_wr;
            m_addr   = e_gd ? d_addr : i_addr;
            m_wdata  = d_wdata;
            m_last_d = e_gd;
        end
        mc++;
    end

    // Start a new cycle: inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("reset mem_en",   32'(mem_en),   32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset d_valid",  32'(d_valid),  32'd0);

        // d read at 0x0010, memory returns 0xBEEF
        cyc();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010; mem_rdata = 16'hBEEF;
        @(negedge clk);
        chk("A d_ready T0", 32'(d_ready), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            cyc(); d_req = 1'b0; d_addr = 16'h7777;
            @(negedge clk);
            chk("A mem_en",   32'(mem_en),   32'd1);
            chk("A mem_addr", 32'(mem_addr), 32'h0010);
            chk("A mem_wr",   32'(mem_wr),   32'd0);
        end
        cyc(); @(negedge clk);
        chk("A d_valid T5", 32'(d_valid), 32'd1);
        chk("A d_rdata T5", 32'(d_rdata), 32'hBEEF);

        // d write 0x1234 to 0x0020
        cyc();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
        @(negedge clk);
        chk("B d_ready T0", 32'(d_ready), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            cyc(); d_req = 1'b0; d_wr = 1'b0; d_wdata = 16'hFFFF;
            @(negedge clk);
            chk("B mem_wr",    32'(mem_wr),    32'd1);
            chk("B mem_wdata", 32'(mem_wdata), 32'h1234);
        end
        cyc(); @(negedge clk);
        chk("B d_valid T5", 32'(d_valid), 32'd1);
        chk("B d_rdata T5", 32'(d_rdata), 32'h0000);
        chk("B i_valid T5", 32'(i_valid), 32'd0);

        // Tie from reset, then fetch address changed after grant
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        cyc();
        i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0040; d_addr = 16'h0030;
        @(negedge clk);
        chk("C d_ready T0", 32'(d_ready), 32'd1);
        chk("C i_ready T0", 32'(i_ready), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            cyc(); d_req = 1'b0;
            @(negedge clk);
            chk("C i_ready wait", 32'(i_ready), 32'd0);
        end
        cyc(); @(negedge clk);
        chk("C i_ready T6", 32'(i_ready), 32'd1);
        for (int k = 7; k <= 10; k++) begin
            cyc(); i_req = 1'b0; i_addr = 16'h0099; mem_rdata = 16'hA5A5;
            @(negedge clk);
            chk("D mem_addr held", 32'(mem_addr), 32'h0040);
            chk("D mem_wr fetch",  32'(mem_wr),   32'd0);
        end
        cyc(); @(negedge clk);
        chk("C i_valid T11", 32'(i_valid), 32'd1);
        chk("C i_rdata T11", 32'(i_rdata), 32'hA5A5);
        chk("C d_valid T11", 32'(d_valid), 32'd0);
        cyc();
        i_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        chk("C tie2 d_ready", 32'(d_ready), 32'd1);
        chk("C tie2 i_ready", 32'(i_ready), 32'd0);
        for (int k = 13; k <= 17; k++) begin
            cyc(); clear_inputs();
        end

        // Reset during BUSY drops the access
        cyc();
        d_req = 1'b1; d_addr = 16'h0050;
        @(negedge clk);
        chk("E d_ready T0", 32'(d_ready), 32'd1);
        cyc(); d_req = 1'b0;
        cyc(); rst = 1'b1;
        @(negedge clk);
        chk("E no ready in rst", 32'(d_ready | i_ready), 32'd0);
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk("E mem_en T3",   32'(mem_en),    32'd0);
        chk("E mem_addr T3", 32'(mem_addr),  32'd0);
        chk("E mem_wd T3",   32'(mem_wdata), 32'd0);
        for (int k = 4; k <= 9; k++) begin
            cyc(); @(negedge clk);
            chk("E no d_valid", 32'(d_valid), 32'd0);
        end

        // Back-to-back fetches with i_req held
        for (int k = 0; k <= 11; k++) begin
            cyc();
            i_req = (k <= 6); i_addr = 16'h0060; mem_rdata = 16'(16'h1000 + k);
            @(negedge clk);
            if (k == 0 || k == 6) chk("F i_ready grant", 32'(i_ready), 32'd1);
            if (k == 5) chk("F i_rdata T5",  32'(i_rdata), 32'h1004);
            if (k == 11) chk("F i_rdata T11", 32'(i_rdata), 32'h100A);
            if (k == 5 || k == 11) chk("F i_valid", 32'(i_valid), 32'd1);
        end

        // Randomized traffic, checked by the model
        for (int k = 0; k < 4000; k++) begin
            cyc();
            rst       = ($urandom_range(0, 99) == 0);
            i_req     = ($urandom_range(0, 99) < 45);
            d_req     = ($urandom_range(0, 99) < 45);
            d_wr      = 1'($urandom);
            i_addr    = 16'($urandom);
            d_addr    = 16'($urandom);
            d_wdata   = 16'($urandom);
            mem_rdata = 16'($urandom);
        end
        cyc(); rst = 1'b0; clear_inputs();
        cyc();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
